// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, forwards from EX/MEM and MEM/WB,
// and raises a one-cycle decode stall with a bubble on a load-use hazard.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ID_VALID,
  input  logic [REG_AW-1:0] ID_RS1,
  input  logic [REG_AW-1:0] ID_RS2,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic [XLEN-1:0]   ID_RDATA1,
  input  logic [XLEN-1:0]   ID_RDATA2,
  input  logic [XLEN-1:0]   ID_IMM,
  input  logic [SEL_W-1:0]  ID_SELECT,
  input  logic              ID_USE_IMM,
  input  logic              ID_REG_WRITE,
  input  logic              ID_MEM_READ,
  input  logic              ID_MEM_WRITE,
  input  logic              FLUSH,
  input  logic              EX_HOLD,
  input  logic [REG_AW-1:0] EXM_RD,
  input  logic              EXM_REG_WRITE,
  input  logic [XLEN-1:0]   EXM_RESULT,
  input  logic [REG_AW-1:0] MWB_RD,
  input  logic              MWB_REG_WRITE,
  input  logic [XLEN-1:0]   MWB_DATA,
  output logic              STALL,
  output logic [XLEN-1:0]   DATA1,
  output logic [XLEN-1:0]   DATA2,
  output logic [SEL_W-1:0]  SELECT,
  output logic [XLEN-1:0]   STORE_DATA,
  output logic              EX_VALID,
  output logic [REG_AW-1:0] EX_RD,
  output logic              EX_REG_WRITE,
  output logic              EX_MEM_READ,
  output logic              EX_MEM_WRITE
);

  typedef struct packed {
    logic [REG_AW-1:0]      rs1;
    logic [REG_AW-1:0]      rs2;
    logic [REG_AW-1:0]      rd;
    logic signed [XLEN-1:0] rdata1;
    logic signed [XLEN-1:0] rdata2;
    logic signed [XLEN-1:0] imm;
    logic [SEL_W-1:0]       sel;
    logic                   use_imm;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
  } stage_t;

  // EX/MEM wins over MEM/WB; x0 always reads the latched register-file value
  function automatic logic signed [XLEN-1:0] fwd(
    input logic [REG_AW-1:0]      rs,
    input logic signed [XLEN-1:0] rf,
    input logic [REG_AW-1:0]      exm_rd,
    input logic                   exm_we,
    input logic signed [XLEN-1:0] exm_val,
    input logic [REG_AW-1:0]      mwb_rd,
    input logic                   mwb_we,
    input logic signed [XLEN-1:0] mwb_val
  );
    if (exm_we && (exm_rd != '0) && (exm_rd == rs))
      return exm_val;
    else if (mwb_we && (mwb_rd != '0) && (mwb_rd == rs))
      return mwb_val;
    else
      return rf;
  endfunction

  stage_t                 id_p0;
  stage_t                 ex_p1;
  logic                   vld_p1;
  logic                   hazard_p0;
  logic                   stall_p0;
  logic signed [XLEN-1:0] src1_p1;
  logic signed [XLEN-1:0] src2_p1;

  // ---- decode side: operand bundle and load-use detection ----
  assign id_p0 = '{rs1: ID_RS1, rs2: ID_RS2, rd: ID_RD,
                   rdata1: ID_RDATA1, rdata2: ID_RDATA2, imm: ID_IMM,
                   sel: ID_SELECT, use_imm: ID_USE_IMM, reg_write: ID_REG_WRITE,
                   mem_read: ID_MEM_READ, mem_write: ID_MEM_WRITE};

  // rs2 only matters when it is actually read: as an ALU operand or as store data
  assign hazard_p0 = vld_p1 & ex_p1.mem_read & ID_VALID & (ex_p1.rd != '0) &
                     ((ex_p1.rd == ID_RS1) |
                      ((ex_p1.rd == ID_RS2) & (~ID_USE_IMM | ID_MEM_WRITE)));
  assign stall_p0  = hazard_p0 & ~FLUSH & ~EX_HOLD;
  assign STALL     = stall_p0;

  // ---- ID/EX register ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vld_p1 <= 1'b0;
      ex_p1  <= '0;
    end else if (FLUSH) begin
      vld_p1 <= 1'b0;
      ex_p1  <= '0;
    end else if (EX_HOLD) begin
      vld_p1 <= vld_p1;
      ex_p1  <= ex_p1;
    end else if (stall_p0) begin
      vld_p1 <= 1'b0;
      ex_p1  <= '0;
    end else begin
      vld_p1 <= ID_VALID;
      ex_p1  <= id_p0;
    end
  end

  // ---- EX side: forwarding and ALU operand drive ----
  assign src1_p1 = fwd(ex_p1.rs1, ex_p1.rdata1, EXM_RD, EXM_REG_WRITE, EXM_RESULT,
                       MWB_RD, MWB_REG_WRITE, MWB_DATA);
  assign src2_p1 = fwd(ex_p1.rs2, ex_p1.rdata2, EXM_RD, EXM_REG_WRITE, EXM_RESULT,
                       MWB_RD, MWB_REG_WRITE, MWB_DATA);

  assign DATA1        = src1_p1;
  assign DATA2        = ex_p1.use_imm ? ex_p1.imm : src2_p1;
  assign STORE_DATA   = src2_p1;
  assign SELECT       = ex_p1.sel;
  assign EX_VALID     = vld_p1;
  assign EX_RD        = ex_p1.rd;
  assign EX_REG_WRITE = vld_p1 & ex_p1.reg_write;
  assign EX_MEM_READ  = vld_p1 & ex_p1.mem_read;
  assign EX_MEM_WRITE = vld_p1 & ex_p1.mem_write;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register feeding the EX-stage ALU. Latches decoded operands and control on each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards, requesting a one-cycle decode stall and inserting a bubble.
- Drives the ALU operand and select inputs (DATA1, DATA2, SELECT) and passes control downstream to EX/MEM.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register index width
SEL_W, 4, ALU select width

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous reset, active-high
ID_VALID  in  1  decode slot holds a real instruction
ID_RS1  in  REG_AW  source register 1 index
ID_RS2  in  REG_AW  source register 2 index
ID_RD  in  REG_AW  destination index
ID_RDATA1  in  XLEN  register-file read data 1
ID_RDATA2  in  XLEN  register-file read data 2
ID_IMM  in  XLEN  sign-extended immediate
ID_SELECT  in  SEL_W  ALU operation code
ID_USE_IMM  in  1  DATA2 takes immediate
ID_REG_WRITE  in  1  writes rd
ID_MEM_READ  in  1  load
ID_MEM_WRITE  in  1  store
FLUSH  in  1  branch/jump redirect; kill the instruction entering EX
EX_HOLD  in  1  downstream stall; freeze this stage
EXM_RD  in  REG_AW  EX/MEM destination
EXM_REG_WRITE  in  1  EX/MEM writes rd (not a load)
EXM_RESULT  in  XLEN  EX/MEM ALU result
MWB_RD  in  REG_AW  MEM/WB destination
MWB_REG_WRITE  in  1  MEM/WB writes rd
MWB_DATA  in  XLEN  MEM/WB writeback value
STALL  out  1  hold PC and IF/ID (load-use)
DATA1  out  XLEN  ALU operand 1
DATA2  out  XLEN  ALU operand 2
SELECT  out  SEL_W  ALU select
STORE_DATA  out  XLEN  forwarded rs2 for stores
EX_VALID  out  1  EX slot holds a real instruction
EX_RD  out  REG_AW  destination, registered
EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE  out  1 each  registered control, all gated by EX_VALID

Behaviour:
- Reset (async, RESET=1): all registered fields go to 0, so EX_VALID=0 and all control outputs are 0.
  - DATA1, DATA2, SELECT and STORE_DATA are driven from the registered zeros, so they read 0 while no forward matches.
  - STALL=0.
- Register update priority on each rising edge, highest first:
  1. RESET
  2. FLUSH: load a bubble (EX_VALID=0, controls 0, data fields don't-care)
  3. EX_HOLD: keep all registers unchanged
  4. STALL: load a bubble
  5. Otherwise: latch all ID_* inputs; EX_VALID<=ID_VALID.
- Load-use detect (combinational):
  - STALL = EX_VALID & EX_MEM_READ & ID_VALID & (EX_RD!=0) & ((EX_RD==ID_RS1) | (EX_RD==ID_RS2 & (~ID_USE_IMM | ID_MEM_WRITE))).
  - STALL is forced to 0 when FLUSH=1 or EX_HOLD=1.
  - Lasts exactly one cycle per hazard. The next cycle the load is in EX/MEM with EXM_REG_WRITE=0, and the MEM/WB forward covers it one cycle later.
- Forwarding (combinational, from the registered rs1 and rs2):
  - For each source: if EXM_REG_WRITE & EXM_RD!=0 & EXM_RD==rs, use EXM_RESULT.
  - Else if MWB_REG_WRITE & MWB_RD!=0 & MWB_RD==rs, use MWB_DATA.
  - Else use the latched register-file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- DATA1 = forwarded rs1.
- DATA2 = latched immediate if USE_IMM, else forwarded rs2.
- STORE_DATA = forwarded rs2, always.
- SELECT = latched select. Bubbles carry SELECT=0.
- Latency: one cycle from ID_* to the EX outputs. Forward paths have zero latency.
- FLUSH together with STALL: the flush wins, STALL is 0, and decode is not frozen.
- EX_HOLD with a pending load-use: no bubble is inserted and STALL=0. Re-evaluate once the hold releases.
- Register-file write-through for the WB→ID same-cycle case is the register file's job, not this block's.

Test Plan:
1. Reset: assert RESET mid-cycle with EX_VALID=1 → all outputs 0 immediately, without waiting for CLK.
2. Forward priority: ADD x5 in EX/MEM (EXM_RESULT=0x11) and in MEM/WB (MWB_DATA=0x22); EX reads rs1=x5 → DATA1=0x11. Drop EXM_REG_WRITE → DATA1=0x22.
3. x0 guard: EXM_RD=0, EXM_REG_WRITE=1, EXM_RESULT=0xFFFF_FFFF, rs1=0, ID_RDATA1=0 → DATA1=0.
4. Load-use: LW x3 in EX, decode ADD x4,x3,x1 → STALL=1 for one cycle, then a bubble in EX (EX_VALID=0). Next cycle the ADD enters EX and takes DATA1 from MWB_DATA.
5. FLUSH and STALL together: same load-use setup with FLUSH=1 → STALL=0 and EX_VALID=0 after the edge.
6. EX_HOLD: hold for 3 cycles while ID inputs change → EX_* and SELECT unchanged. Release → the new ID values are latched.
